// File: rtl/goomba_pkg.sv
// rtl/goomba_pkg.sv - shared goomba geometry, timing constants and state encoding
package goomba_pkg;

   typedef enum logic [2:0] {
      ST_WALK   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_FALL   = 3'd2,
      ST_SQUISH = 3'd3,
      ST_WAIT   = 3'd4
   } goomba_state_e;

   localparam logic [9:0] WIDTH          = 10'd26;
   localparam logic [9:0] HEIGHT         = 10'd27;
   localparam logic [9:0] FLOOR_Y        = 10'd413;
   localparam logic [9:0] X_MAX          = 10'd614;
   localparam logic [9:0] WALK_SPEED     = 10'd1;
   localparam logic [2:0] GRAVITY        = 3'd1;
   localparam logic [2:0] MAX_FALL       = 3'd6;
   localparam logic [9:0] SPAWN_LX       = 10'd40;
   localparam logic [9:0] SPAWN_RX       = 10'd574;
   localparam logic [9:0] SPAWN_Y        = 10'd35;
   localparam logic [9:0] SCREEN_MID_X   = 10'd320;
   localparam logic [6:0] SQUISH_FRAMES  = 7'd30;
   localparam logic [6:0] RESPAWN_FRAMES = 7'd90;

endpackage

// File: rtl/goomba_fall_stepper.sv
// rtl/goomba_fall_stepper.sv - fall velocity/budget tracking, one pixel step per clk
module goomba_fall_stepper
   import goomba_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic active,
   input  logic frame_tick,
   input  logic ground,
   input  logic at_floor,
   output logic step_en,
   output logic landed
);

   logic [2:0] vel_q, vel_d;
   logic [2:0] budget_q, budget_d;

   always_comb begin
      vel_d    = vel_q;
      budget_d = budget_q;
      step_en  = 1'b0;
      landed   = 1'b0;
      if (start || !active) begin
         vel_d    = 3'd0;
         budget_d = 3'd0;
      end else if (budget_q != 3'd0) begin
         // ground is checked before every pixel so the detector's exact match is never skipped
         if (ground || at_floor) begin
            landed   = 1'b1;
            vel_d    = 3'd0;
            budget_d = 3'd0;
         end else begin
            step_en  = 1'b1;
            budget_d = budget_q - 3'd1;
         end
      end else if (frame_tick) begin
         vel_d    = (vel_q >= MAX_FALL - GRAVITY) ? MAX_FALL : vel_q + GRAVITY;
         budget_d = vel_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vel_q    <= 3'd0;
         budget_q <= 3'd0;
      end else begin
         vel_q    <= vel_d;
         budget_q <= budget_d;
      end
   end

endmodule

// File: rtl/goomba_motion.sv
// rtl/goomba_motion.sv - goomba position controller: walk, fall, edge turn, squish, respawn
module goomba_motion
   import goomba_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       ground,
   input  logic       stomp,
   output logic [9:0] goomba_x,
   output logic [9:0] goomba_y,
   output logic       dir,
   output logic       alive,
   output logic       squished,
   output logic [2:0] state
);

   goomba_state_e state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       dir_q, dir_d;
   logic       alive_q, alive_d;
   logic       squished_q, squished_d;
   logic       exit_side_q, exit_side_d;
   logic [6:0] cnt_q, cnt_d;

   logic        fall_start;
   logic        step_en;
   logic        landed;
   logic        at_floor;
   logic        at_edge;
   logic [10:0] x_sum;
   logic [9:0]  x_right;
   logic [9:0]  x_left;
   logic [6:0]  cnt_dec;

   assign at_floor = (y_q == FLOOR_Y);
   assign at_edge  = (!dir_q && x_q == X_MAX) || (dir_q && x_q == 10'd0);
   assign x_sum    = {1'b0, x_q} + {1'b0, WALK_SPEED};
   assign x_right  = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
   assign x_left   = (x_q < WALK_SPEED) ? 10'd0 : x_q - WALK_SPEED;
   assign cnt_dec  = cnt_q - 7'd1;

   goomba_fall_stepper u_fall (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (fall_start),
      .active     (state_q == ST_FALL),
      .frame_tick (frame_tick),
      .ground     (ground),
      .at_floor   (at_floor),
      .step_en    (step_en),
      .landed     (landed)
   );

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dir_d       = dir_q;
      alive_d     = alive_q;
      squished_d  = squished_q;
      exit_side_d = exit_side_q;
      cnt_d       = cnt_q;
      fall_start  = 1'b0;

      case (state_q)
         ST_WALK, ST_CHECK, ST_FALL: begin
            if (stomp) begin
               state_d    = ST_SQUISH;
               squished_d = 1'b1;
               cnt_d      = SQUISH_FRAMES;
            end else if (state_q == ST_WALK) begin
               if (frame_tick) begin
                  if (at_edge && at_floor) begin
                     state_d     = ST_WAIT;
                     alive_d     = 1'b0;
                     exit_side_d = dir_q;
                     cnt_d       = RESPAWN_FRAMES;
                  end else if (at_edge) begin
                     dir_d   = ~dir_q;
                     state_d = ST_CHECK;
                  end else begin
                     x_d     = dir_q ? x_left : x_right;
                     state_d = ST_CHECK;
                  end
               end
            end else if (state_q == ST_CHECK) begin
               // one clk here lets the detector see the freshly moved x
               if (ground || at_floor) begin
                  state_d = ST_WALK;
               end else begin
                  state_d    = ST_FALL;
                  fall_start = 1'b1;
               end
            end else begin
               if (landed) begin
                  state_d = ST_WALK;
               end else if (step_en) begin
                  y_d = y_q + 10'd1;
               end
            end
         end

         ST_SQUISH: begin
            if (frame_tick) begin
               if (cnt_dec == 7'd0) begin
                  state_d     = ST_WAIT;
                  alive_d     = 1'b0;
                  squished_d  = 1'b0;
                  cnt_d       = RESPAWN_FRAMES;
                  exit_side_d = (x_q < SCREEN_MID_X);
               end else begin
                  cnt_d = cnt_dec;
               end
            end
         end

         ST_WAIT: begin
            if (frame_tick) begin
               if (cnt_dec == 7'd0) begin
                  state_d = ST_CHECK;
                  x_d     = exit_side_q ? SPAWN_RX : SPAWN_LX;
                  dir_d   = exit_side_q;
                  y_d     = SPAWN_Y;
                  alive_d = 1'b1;
                  cnt_d   = 7'd0;
               end else begin
                  cnt_d = cnt_dec;
               end
            end
         end

         default: begin
            state_d = ST_WALK;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_WALK;
         x_q         <= SPAWN_LX;
         y_q         <= SPAWN_Y;
         dir_q       <= 1'b0;
         alive_q     <= 1'b1;
         squished_q  <= 1'b0;
         exit_side_q <= 1'b0;
         cnt_q       <= 7'd0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_q       <= dir_d;
         alive_q     <= alive_d;
         squished_q  <= squished_d;
         exit_side_q <= exit_side_d;
         cnt_q       <= cnt_d;
      end
   end

   assign goomba_x = x_q;
   assign goomba_y = y_q;
   assign dir      = dir_q;
   assign alive    = alive_q;
   assign squished = squished_q;
   assign state    = state_q;

endmodule
